// File: rtl/m_ext_issue_ctrl.sv
// m_ext_issue_ctrl: issue/stall controller in front of the multi-cycle M unit.
// Holds operands stable, resolves trivial DIV/REM cases, presents one result per op.
module m_ext_issue_ctrl #(
    parameter int WIDTH       = 32,
    parameter bit SHORTCUT_EN = 1'b1,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             m_enable_o,
    output logic [2:0]       m_funct3_o,
    output logic [WIDTH-1:0] m_a_o,
    output logic [WIDTH-1:0] m_b_o,
    input  logic [WIDTH-1:0] m_f_i,
    input  logic             m_resp_i,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o,
    output logic             stall_o,
    output logic             err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   tmo_q;
    logic [CW-1:0]   tmo_d;
    logic            err_d;
    logic            en_d;
    logic            latch;
    logic            res_load;
    logic [WIDTH-1:0] res_d;
    logic            sc_hit;
    logic [WIDTH-1:0] sc_val;

    // Divide-by-zero and INT_MIN / -1 have architecturally fixed results.
    always_comb begin
        sc_hit = 1'b0;
        sc_val = '0;
        if (SHORTCUT_EN && funct3_i[2]) begin
            if (rs2_i == '0) begin
                sc_hit = 1'b1;
                sc_val = funct3_i[1] ? rs1_i : ALL_ONES;
            end else if (!funct3_i[0] && rs1_i == INT_MIN && rs2_i == ALL_ONES) begin
                sc_hit = 1'b1;
                sc_val = funct3_i[1] ? '0 : INT_MIN;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        tmo_d    = '0;
        err_d    = err_o;
        latch    = 1'b0;
        res_load = 1'b0;
        res_d    = m_f_i;
        unique case (state_q)
            IDLE: begin
                if (valid_i && !flush_i) begin
                    latch = 1'b1;
                    if (sc_hit) begin
                        res_load = 1'b1;
                        res_d    = sc_val;
                        state_d  = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (m_resp_i) begin
                    res_load = !flush_i;
                    state_d  = flush_i ? IDLE : DONE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d   = tmo_q + CW'(1);
                    state_d = flush_i ? DRAIN : BUSY;
                end
            end
            DRAIN: begin
                // The unit cannot be aborted; wait it out and drop its result.
                if (m_resp_i) begin
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            DONE: begin
                if (flush_i || !hold_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign en_d = (state_d == BUSY) || (state_d == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            err_o      <= 1'b0;
            m_enable_o <= 1'b0;
            m_funct3_o <= '0;
            m_a_o      <= '0;
            m_b_o      <= '0;
            result_o   <= '0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            err_o      <= err_d;
            m_enable_o <= en_d;
            if (latch) begin
                m_funct3_o <= funct3_i;
                m_a_o      <= rs1_i;
                m_b_o      <= rs2_i;
            end
            if (res_load) begin
                result_o <= res_d;
            end
        end
    end

    assign result_valid_o = (state_q == DONE);

    assign stall_o = ((state_q == IDLE) && valid_i && !flush_i)
                   || (state_q == BUSY)
                   || ((state_q == DRAIN) && valid_i)
                   || ((state_q == DONE) && hold_i);

endmodule
